// File: rtl/noc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | noc_pkg: shared types and width helpers for the NoC inject arbiter     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package noc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic int vc_width(input int num_vc);
      return (num_vc > 1) ? $clog2(num_vc) : 1;
   endfunction

   function automatic int cred_width(input int cred_max);
      return $clog2(cred_max + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/noc_inject_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | noc_inject_arbiter_if: requester, router channel and credit signals    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface noc_inject_arbiter_if
   import noc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int FLIT_W  = 64,
   parameter int NUM_VC  = 2
);
   localparam int VC_W = vc_width(NUM_VC);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*FLIT_W-1:0] req_flit;
   logic [NUM_REQ-1:0]        req_tail;
   logic [NUM_REQ*VC_W-1:0]   req_vc;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic                      out_head;
   logic                      out_tail;
   logic [FLIT_W-1:0]         out_flit;
   logic [VC_W-1:0]           out_vc;
   logic                      cred_valid;
   logic [VC_W-1:0]           cred_vc;
   logic [NUM_REQ-1:0]        owner;
   logic                      error;

   modport master (
      output req_valid, req_flit, req_tail, req_vc, cred_valid, cred_vc,
      input  req_ready, out_valid, out_head, out_tail, out_flit, out_vc,
             owner, error
   );

   modport slave (
      input  req_valid, req_flit, req_tail, req_vc, cred_valid, cred_vc,
      output req_ready, out_valid, out_head, out_tail, out_flit, out_vc,
             owner, error
   );

endinterface
`default_nettype wire

// File: rtl/noc_credit_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | noc_credit_counter: saturating per-VC credit count with overflow pulse |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module noc_credit_counter
   import noc_pkg::*;
#(
   parameter int CRED_MAX = 8,
   parameter int CNT_W    = cred_width(CRED_MAX)
)(
   input  logic clk,
   input  logic reset,
   input  logic i_dec,
   input  logic i_inc,
   output logic o_nonzero,
   output logic o_overflow
);
   localparam logic [CNT_W-1:0] c_cred_max = CNT_W'(CRED_MAX);

   logic [CNT_W-1:0] r_count;

   // A simultaneous spend and return cancel out, so only lone events move the count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= c_cred_max;
      end else if (i_inc && !i_dec) begin
         if (r_count != c_cred_max) r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) r_count <= r_count - 1'b1;
      end
   end

   assign o_nonzero  = (r_count != '0);
   assign o_overflow = i_inc && !i_dec && (r_count == c_cred_max);

endmodule
`default_nettype wire

// File: rtl/noc_inject_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | noc_inject_arbiter: packet-locked round-robin injection with credits   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module noc_inject_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int FLIT_W   = 64,
   parameter int NUM_VC   = 2,
   parameter int CRED_MAX = 8
)(
   input  logic               clk,
   input  logic               reset,
   noc_inject_arbiter_if.slave bus
);
   localparam int VC_W  = vc_width(NUM_VC);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_owner_idx;
   logic [NUM_REQ-1:0] r_owner;
   logic [VC_W-1:0]    r_vc;
   logic               r_out_valid;
   logic               r_out_head;
   logic               r_out_tail;
   logic [FLIT_W-1:0]  r_out_flit;
   logic [VC_W-1:0]    r_out_vc;
   logic               r_error;

   logic [NUM_VC-1:0]  w_cred_ok;
   logic [NUM_VC-1:0]  w_cred_dec;
   logic [NUM_VC-1:0]  w_cred_inc;
   logic [NUM_VC-1:0]  w_cred_ovf;
   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_grant_vld;
   logic [PTR_W-1:0]   w_grant_idx;
   logic               w_acc;
   logic [PTR_W-1:0]   w_acc_idx;
   logic [VC_W-1:0]    w_acc_vc;
   logic               w_acc_tail;
   logic [FLIT_W-1:0]  w_acc_flit;

   // Lowest offset from the pointer wins; scanning downward lets it overwrite last.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                input logic [PTR_W-1:0]   ptr);
      logic [PTR_W-1:0] pick;
      int               idx;
      pick = ptr;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NUM_REQ;
         if (elig[idx]) pick = PTR_W'(idx);
      end
      return pick;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_valid[i] && (int'(bus.req_vc[i*VC_W +: VC_W]) < NUM_VC))
            w_elig[i] = w_cred_ok[bus.req_vc[i*VC_W +: VC_W]];
      end
   end

   assign w_grant_vld = |w_elig;
   assign w_grant_idx = rr_pick(w_elig, r_ptr);

   always_comb begin
      w_ready = '0;
      if (reset) begin
         if (r_state == ST_IDLE) begin
            if (w_grant_vld) w_ready[w_grant_idx] = 1'b1;
         end else begin
            w_ready = r_owner & {NUM_REQ{w_cred_ok[r_vc]}};
         end
      end
   end

   assign w_acc      = |(w_ready & bus.req_valid);
   assign w_acc_idx  = (r_state == ST_IDLE) ? w_grant_idx : r_owner_idx;
   assign w_acc_vc   = (r_state == ST_IDLE) ? bus.req_vc[w_grant_idx*VC_W +: VC_W] : r_vc;
   assign w_acc_tail = bus.req_tail[w_acc_idx];
   assign w_acc_flit = bus.req_flit[w_acc_idx*FLIT_W +: FLIT_W];

   generate
      for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
         assign w_cred_dec[v] = w_acc && (w_acc_vc == VC_W'(v));
         assign w_cred_inc[v] = bus.cred_valid && (bus.cred_vc == VC_W'(v));

         noc_credit_counter #(
            .CRED_MAX (CRED_MAX)
         ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .i_dec      (w_cred_dec[v]),
            .i_inc      (w_cred_inc[v]),
            .o_nonzero  (w_cred_ok[v]),
            .o_overflow (w_cred_ovf[v])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_owner_idx <= '0;
         r_vc        <= '0;
         r_out_valid <= 1'b0;
         r_out_head  <= 1'b0;
         r_out_tail  <= 1'b0;
         r_out_flit  <= '0;
         r_out_vc    <= '0;
         r_error     <= 1'b0;
      end else begin
         r_out_valid <= w_acc;
         r_out_head  <= w_acc && (r_state == ST_IDLE);
         r_out_tail  <= w_acc && w_acc_tail;
         if (w_acc) begin
            r_out_flit <= w_acc_flit;
            r_out_vc   <= w_acc_vc;
         end
         r_error <= r_error | (|w_cred_ovf);

         case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  if (w_acc_tail) begin
                     r_ptr <= next_ptr(w_acc_idx);
                  end else begin
                     r_state     <= ST_LOCKED;
                     r_owner     <= w_ready;
                     r_owner_idx <= w_acc_idx;
                     r_vc        <= w_acc_vc;
                  end
               end
            end
            ST_LOCKED: begin
               if (w_acc && w_acc_tail) begin
                  r_state <= ST_IDLE;
                  r_owner <= '0;
                  r_ptr   <= next_ptr(r_owner_idx);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_head  = r_out_head;
   assign bus.out_tail  = r_out_tail;
   assign bus.out_flit  = r_out_flit;
   assign bus.out_vc    = r_out_vc;
   assign bus.owner     = r_owner;
   assign bus.error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_noc_inject_arbiter: directed self-checking bench for the arbiter    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_noc_inject_arbiter;
   localparam int c_NUM_REQ  = 4;
   localparam int c_FLIT_W   = 64;
   localparam int c_NUM_VC   = 2;
   localparam int c_CRED_MAX = 8;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   noc_inject_arbiter_if #(
      .NUM_REQ (c_NUM_REQ),
      .FLIT_W  (c_FLIT_W),
      .NUM_VC  (c_NUM_VC)
   ) ifc ();

   noc_inject_arbiter #(
      .NUM_REQ  (c_NUM_REQ),
      .FLIT_W   (c_FLIT_W),
      .NUM_VC   (c_NUM_VC),
      .CRED_MAX (c_CRED_MAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic drive(input int i, input logic v, input logic [63:0] f,
                        input logic t, input logic vc);
      ifc.req_valid[i]          = v;
      ifc.req_flit[i*64 +: 64]  = f;
      ifc.req_tail[i]           = t;
      ifc.req_vc[i]             = vc;
   endtask

   task automatic clr();
      ifc.req_valid  = '0;
      ifc.req_flit   = '0;
      ifc.req_tail   = '0;
      ifc.req_vc     = '0;
      ifc.cred_valid = 1'b0;
      ifc.cred_vc    = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      clr();
      ifc.req_valid = 4'b1111;
      tick();
      tick();
      mid();
      chk("rst_ready", ifc.req_ready, 4'b0000);
      chk("rst_out_valid", ifc.out_valid, 1'b0);
      chk("rst_out_head", ifc.out_head, 1'b0);
      chk("rst_out_tail", ifc.out_tail, 1'b0);
      chk("rst_out_flit", ifc.out_flit, 64'h0);
      chk("rst_owner", ifc.owner, 4'b0000);
      chk("rst_error", ifc.error, 1'b0);
      clr();
      reset = 1'b1;
      tick();

      // 3-flit packet from req0 on VC0; VC input changes mid-packet are ignored.
      drive(0, 1'b1, 64'hA0, 1'b0, 1'b0);
      mid();
      chk("p3_ready_f1", ifc.req_ready, 4'b0001);
      tick();
      chk("p3_valid_f1", ifc.out_valid, 1'b1);
      chk("p3_head_f1", ifc.out_head, 1'b1);
      chk("p3_tail_f1", ifc.out_tail, 1'b0);
      chk("p3_flit_f1", ifc.out_flit, 64'hA0);
      chk("p3_owner_f1", ifc.owner, 4'b0001);
      drive(0, 1'b1, 64'hA1, 1'b0, 1'b1);
      mid();
      chk("p3_ready_f2", ifc.req_ready, 4'b0001);
      tick();
      chk("p3_valid_f2", ifc.out_valid, 1'b1);
      chk("p3_head_f2", ifc.out_head, 1'b0);
      chk("p3_flit_f2", ifc.out_flit, 64'hA1);
      chk("p3_vc_f2", ifc.out_vc, 1'b0);
      drive(0, 1'b1, 64'hA2, 1'b1, 1'b1);
      mid();
      chk("p3_ready_f3", ifc.req_ready, 4'b0001);
      tick();
      chk("p3_valid_f3", ifc.out_valid, 1'b1);
      chk("p3_tail_f3", ifc.out_tail, 1'b1);
      chk("p3_flit_f3", ifc.out_flit, 64'hA2);
      chk("p3_owner_done", ifc.owner, 4'b0000);
      clr();
      tick();
      chk("p3_valid_after", ifc.out_valid, 1'b0);

      // VC0 credit 5 -> 4, then a spend with a same-cycle return keeps it at 4.
      drive(0, 1'b1, 64'hB0, 1'b1, 1'b0);
      mid();
      chk("c4_ready_pre", ifc.req_ready, 4'b0001);
      tick();
      drive(0, 1'b1, 64'hB1, 1'b1, 1'b0);
      ifc.cred_valid = 1'b1;
      ifc.cred_vc    = 1'b0;
      mid();
      chk("c4_ready_both", ifc.req_ready, 4'b0001);
      tick();
      ifc.cred_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b1, 64'hB2 + 64'(k), 1'b1, 1'b0);
         mid();
         chk("c4_drain_ready", ifc.req_ready, 4'b0001);
         tick();
      end
      mid();
      chk("c4_empty_ready", ifc.req_ready, 4'b0000);
      clr();
      ifc.cred_valid = 1'b1;
      ifc.cred_vc    = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      clr();
      chk("refill0_error", ifc.error, 1'b0);

      // Move the pointer to 0 via req3, then all four requesters with 1-flit packets.
      drive(3, 1'b1, 64'h103, 1'b1, 1'b0);
      mid();
      chk("rr_pre_ready", ifc.req_ready, 4'b1000);
      tick();
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("rr_ready", ifc.req_ready, 4'b0001 << (k % 4));
         tick();
         chk("rr_flit", ifc.out_flit, 64'h100 + 64'(k % 4));
         chk("rr_head_tail", {ifc.out_head, ifc.out_tail}, 2'b11);
      end
      clr();
      tick();

      // 9-flit packet on VC1 stalls on the 9th flit until one credit comes back.
      for (int k = 1; k <= 8; k++) begin
         drive(2, 1'b1, 64'h200 + 64'(k), 1'b0, 1'b1);
         mid();
         chk("stall_ready", ifc.req_ready, 4'b0100);
         tick();
         chk("stall_head", ifc.out_head, (k == 1) ? 1'b1 : 1'b0);
      end
      drive(2, 1'b1, 64'h209, 1'b1, 1'b1);
      ifc.cred_valid = 1'b1;
      ifc.cred_vc    = 1'b1;
      mid();
      chk("stall_ready_9", ifc.req_ready, 4'b0000);
      chk("stall_owner", ifc.owner, 4'b0100);
      tick();
      ifc.cred_valid = 1'b0;
      chk("stall_nothing_out", ifc.out_valid, 1'b0);
      mid();
      chk("stall_ready_resume", ifc.req_ready, 4'b0100);
      tick();
      chk("stall_valid_9", ifc.out_valid, 1'b1);
      chk("stall_tail_9", ifc.out_tail, 1'b1);
      chk("stall_flit_9", ifc.out_flit, 64'h209);
      chk("stall_vc_9", ifc.out_vc, 1'b1);
      clr();
      ifc.cred_valid = 1'b1;
      ifc.cred_vc    = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      clr();

      // req1 holds the lock; req2 waits until req1's tail has been accepted.
      drive(1, 1'b1, 64'h201, 1'b0, 1'b1);
      mid();
      chk("lock_ready_h", ifc.req_ready, 4'b0010);
      tick();
      chk("lock_owner", ifc.owner, 4'b0010);
      drive(1, 1'b1, 64'h202, 1'b0, 1'b1);
      drive(2, 1'b1, 64'h300, 1'b1, 1'b1);
      mid();
      chk("lock_ready_b", ifc.req_ready, 4'b0010);
      tick();
      drive(1, 1'b1, 64'h203, 1'b1, 1'b1);
      mid();
      chk("lock_ready_t", ifc.req_ready, 4'b0010);
      tick();
      chk("lock_tail_flit", ifc.out_flit, 64'h203);
      chk("lock_owner_free", ifc.owner, 4'b0000);
      drive(1, 1'b0, 64'h0, 1'b0, 1'b0);
      mid();
      chk("lock_ready_req2", ifc.req_ready, 4'b0100);
      tick();
      chk("lock_req2_flit", ifc.out_flit, 64'h300);
      clr();

      // VC0 at 2: six returns fill it, a seventh overflows and sets the sticky error.
      ifc.cred_valid = 1'b1;
      ifc.cred_vc    = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("ovf_error_pre", ifc.error, 1'b0);
      tick();
      clr();
      chk("ovf_error_set", ifc.error, 1'b1);
      tick();
      tick();
      chk("ovf_error_sticky", ifc.error, 1'b1);
      for (int k = 0; k < 8; k++) begin
         drive(0, 1'b1, 64'h400 + 64'(k), 1'b1, 1'b0);
         mid();
         chk("sat_ready", ifc.req_ready, 4'b0001);
         tick();
      end
      mid();
      chk("sat_ready_9", ifc.req_ready, 4'b0000);
      clr();
      tick();

      // Reset in the middle of a packet abandons it.
      drive(0, 1'b1, 64'h500, 1'b0, 1'b1);
      mid();
      chk("mid_rst_ready_h", ifc.req_ready, 4'b0001);
      tick();
      chk("mid_rst_owner_pre", ifc.owner, 4'b0001);
      drive(0, 1'b1, 64'h501, 1'b1, 1'b1);
      reset = 1'b0;
      mid();
      chk("mid_rst_ready", ifc.req_ready, 4'b0000);
      tick();
      chk("mid_rst_owner", ifc.owner, 4'b0000);
      chk("mid_rst_valid", ifc.out_valid, 1'b0);
      chk("mid_rst_error", ifc.error, 1'b0);
      reset = 1'b1;
      clr();
      tick();
      chk("post_rst_valid", ifc.out_valid, 1'b0);
      drive(1, 1'b1, 64'h600, 1'b1, 1'b1);
      mid();
      chk("post_rst_ready", ifc.req_ready, 4'b0010);
      tick();
      chk("post_rst_head_tail", {ifc.out_head, ifc.out_tail}, 2'b11);
      chk("post_rst_flit", ifc.out_flit, 64'h600);
      clr();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of local injecting requesters.
REQ-002 SHALL have parameter FLIT_W, default 64, meaning flit payload width in bits.
REQ-003 SHALL have parameter NUM_VC, default 2, meaning virtual channels on the router input port; VC_W = max(1, clog2(NUM_VC)).
REQ-004 SHALL have parameter CRED_MAX, default 8, meaning buffer depth per VC at the router input, which is also the credit reset value.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-low reset (0 = reset).
REQ-007 SHALL have port req_valid, input, NUM_REQ, meaning per-requester flit available.
REQ-008 SHALL have port req_flit, input, NUM_REQ*FLIT_W, meaning per-requester flit payload; requester i occupies slice i.
REQ-009 SHALL have port req_tail, input, NUM_REQ, meaning the current flit is the last of its packet.
REQ-010 SHALL have port req_vc, input, NUM_REQ*VC_W, meaning the target VC, sampled on head flit only.
REQ-011 SHALL have port req_ready, output, NUM_REQ, meaning the flit is accepted this cycle when ANDed with req_valid.
REQ-012 SHALL have port out_valid / out_head / out_tail, output, 1 each, meaning flit strobe and packet delimiters to the router channel.
REQ-013 SHALL have port out_flit, output, FLIT_W, meaning payload to the router channel.
REQ-014 SHALL have port out_vc, output, VC_W, meaning the VC of the output flit.
REQ-015 SHALL have port cred_valid, input, 1, and cred_vc, input, VC_W, meaning one credit returned by the router for cred_vc.
REQ-016 SHALL have port owner, output, NUM_REQ, meaning one-hot packet lock holder; zero when idle.
REQ-017 SHALL have port error, output, 1, meaning sticky credit-overflow flag.

Function
REQ-018 SHALL implement FSM IDLE and LOCKED; the lock is held from the head flit to the tail flit of one packet.
REQ-019 SHALL, in IDLE, grant round-robin among valid requesters whose req_vc has credit > 0, starting at the pointer; arbitration costs zero cycles, so the head flit is accepted in the same cycle it is granted.
REQ-020 SHALL, in LOCKED, assert req_ready only for the owner, and only when the credit of the latched VC is > 0.
REQ-021 SHALL latch the VC at the head; req_vc changes mid-packet are ignored.
REQ-022 SHALL return to IDLE on tail acceptance and advance the pointer to owner+1 mod NUM_REQ; a single-flit packet passes IDLE->IDLE with the pointer advanced.
REQ-023 SHALL register the output with fixed latency 1: a flit accepted in cycle N appears with out_valid=1 in cycle N+1, out_head=1 on the first flit of the packet, and out_tail equal to req_tail.
REQ-024 SHALL decrement the credit at acceptance and increment it on cred_valid; if both occur in the same cycle on the same VC, the count is unchanged.
REQ-025 SHALL, when cred_valid arrives while the counter equals CRED_MAX, saturate the counter and set error; error clears only on reset.
REQ-026 SHALL size credit counters clog2(CRED_MAX+1) bits, unsigned, and never wrap below 0.
REQ-027 SHALL keep the pointer unchanged when no grant occurs.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, set the FSM to IDLE, the pointer to 0, owner to 0, all credits to CRED_MAX, and out_valid, out_head, out_tail, out_flit, out_vc and error to 0.
REQ-029 SHALL hold req_ready at 0 during reset; a packet in flight at reset is abandoned, and no tail is emitted for it.

Structure
REQ-030 SHALL place VC_W derivation, the FSM state enum and the credit-width function in shared package noc_pkg.
REQ-031 SHALL instantiate one sub-module, noc_credit_counter, once per VC.

Verification
REQ-032 SHALL cover: after reset, req0 sends a 3-flit packet on VC0 -> out_valid for 3 consecutive cycles starting 1 cycle later, head on flit 1, tail on flit 3, credit0 = 5.
REQ-033 SHALL cover: req0..req3 all valid with 1-flit packets -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-034 SHALL cover: req1 locked mid-packet while req2 asserts valid -> req2 is not granted until req1's tail is accepted.
REQ-035 SHALL cover: 8 flits on VC1 with no credit return -> req_ready=0 on the 9th; one cred_valid on VC1 -> the 9th flit is accepted the next cycle.
REQ-036 SHALL cover: acceptance and cred_valid on VC0 in the same cycle with credit 4 -> credit stays 4.
REQ-037 SHALL cover: cred_valid on VC0 at credit 8 -> error=1 and persists; reset=0 mid-packet -> owner=0 and out_valid=0 the next cycle.
